mc_control_fsm: RTL and testbench

Multi-cycle control sequencer for the RV32I core. It replaces single-cycle decoding with a state machine that drives the shared ALU, the unified instruction/data memory port, the register file and the PC. It inserts wait states while the memory/SPI bus holds mem_ready low. It halts the core on an illegal opcode or on a bus timeout.

---
 rtl/mc_control_fsm.sv | 199 +++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle RV32I control sequencer with memory wait states and bus timeout.
// Optional MC_RETIRE_CNT_EN adds a retired-instruction counter output.
module mc_control_fsm #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TMO_W       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_update,
    output logic       adr_src,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic [2:0] imm_src,
`ifdef MC_RETIRE_CNT_EN
    output logic [31:0] retired,
`endif
    output logic       halted,
    output logic [1:0] err_code
);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
        ALUWB, BEQ, JAL, JALR, JALRWB, LUI, AUIPC, HALT
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       err_q, err_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             wait_st, tmo_hit;

    assign imm_src = (op == OP_STORE) ? 3'b001 :
                     (op == OP_BR) ? 3'b010 :
                     (op == OP_JAL) ? 3'b011 :
                     (op == OP_LUI || op == OP_AUIPC) ? 3'b100 : 3'b000;
    assign err_code = err_q;
    assign wait_st  = state_q == FETCH || state_q == MEMREAD || state_q == MEMWRITE;
    assign tmo_hit  = wait_st && !mem_ready && tmo_q == TMO_W'(MEM_TIMEOUT);

    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        pc_update  = 1'b0;
        adr_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        result_src = 2'b00;
        halted     = 1'b0;
        case (state_q)
            FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_update  = mem_ready;
                state_d    = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_R:              state_d = EXECR;
                    OP_I:              state_d = EXECI;
                    OP_BR:             state_d = BEQ;
                    OP_JAL:            state_d = JAL;
                    OP_JALR:           state_d = JALR;
                    OP_LUI:            state_d = LUI;
                    OP_AUIPC:          state_d = AUIPC;
                    default: begin
                        state_d = HALT;
                        err_d   = 2'b01;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adr_src  = 1'b1;
                mem_read = 1'b1;
                state_d  = mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = !tmo_hit;
                state_d   = mem_ready ? FETCH : MEMWRITE;
            end
            EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = ALUWB;
            end
            EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pc_update = zero;
                state_d   = FETCH;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
                state_d   = ALUWB;
            end
            JALR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_update  = 1'b1;
                state_d    = JALRWB;
            end
            JALRWB: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
            LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
                state_d   = ALUWB;
            end
            AUIPC: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                state_d   = ALUWB;
            end
            default: halted = 1'b1;
        endcase
        if (tmo_hit) begin
            state_d = HALT;
            err_d   = 2'b10;
        end
        // any state change clears the counter, which covers every entry into a wait state
        tmo_d = (state_d != state_q) ? '0 : (wait_st && !mem_ready) ? tmo_q + TMO_W'(1) : tmo_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH;
            err_q   <= 2'b00;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

`ifdef MC_RETIRE_CNT_EN
    logic [31:0] ret_q;
    assign retired = ret_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ret_q <= '0;
        else if (state_d == FETCH && state_q != FETCH) ret_q <= ret_q + 32'd1;
    end
`endif
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: directed and randomized checks of mc_control_fsm against a phase-list model.
module tb_mc_control_fsm;
    localparam int TMO = 4;

    logic       clk = 1'b0, rst = 1'b0, zero = 1'b0, mem_ready = 1'b0;
    logic [6:0] op = 7'b0110011;
    logic       pc_update, adr_src, mem_read, mem_write, ir_write, reg_write, halted;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src, err_code;
    logic [2:0] imm_src;
`ifdef MC_RETIRE_CNT_EN
    logic [31:0] retired;
    int unsigned m_ret = 0;
`endif

    int checks = 0, errors = 0;
    logic       m_halt = 1'b0;
    logic [1:0] m_err = 2'b00;

    mc_control_fsm #(.MEM_TIMEOUT(TMO), .TMO_W(16)) dut (
        .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pc_update(pc_update), .adr_src(adr_src), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .result_src(result_src), .imm_src(imm_src),
`ifdef MC_RETIRE_CNT_EN
        .retired(retired),
`endif
        .halted(halted), .err_code(err_code)
    );

    always #5 clk = ~clk;

    wire [19:0] obs = {pc_update, adr_src, mem_read, mem_write, ir_write, reg_write, alu_src_a,
                       alu_src_b, alu_op, result_src, imm_src, halted, err_code};

    function automatic logic [19:0] exp_vec(string p, logic rdy, logic z, logic [6:0] o, logic [1:0] e, logic tmo);
        logic       pcu = 0, adr = 0, mr = 0, mw = 0, irw = 0, rw = 0, h = 0;
        logic [1:0] a = 0, b = 0, aop = 0, rs = 0;
        logic [2:0] imm;
        imm = (o == 7'b0100011) ? 3'd1 : (o == 7'b1100011) ? 3'd2 : (o == 7'b1101111) ? 3'd3 :
              (o == 7'b0110111 || o == 7'b0010111) ? 3'd4 : 3'd0;
        if (p == "FETCH") begin mr = 1; b = 2; rs = 2; irw = rdy; pcu = rdy; end
        else if (p == "DECODE") begin a = 1; b = 1; end
        else if (p == "MEMADR") begin a = 2; b = 1; end
        else if (p == "MEMREAD") begin adr = 1; mr = 1; end
        else if (p == "MEMWB") begin rs = 1; rw = 1; end
        else if (p == "MEMWRITE") begin adr = 1; mw = !tmo; end
        else if (p == "EXECR") begin a = 2; aop = 2; end
        else if (p == "EXECI") begin a = 2; b = 1; aop = 2; end
        else if (p == "ALUWB") rw = 1;
        else if (p == "BEQ") begin a = 2; aop = 1; pcu = z; end
        else if (p == "JAL") begin a = 1; b = 2; pcu = 1; end
        else if (p == "JALR") begin a = 2; b = 1; rs = 2; pcu = 1; end
        else if (p == "JALRWB") begin a = 1; b = 2; rs = 2; rw = 1; end
        else if (p == "LUI") begin a = 3; b = 1; end
        else if (p == "AUIPC") begin a = 1; b = 1; end
        else if (p == "HALT") h = 1;
        return {pcu, adr, mr, mw, irw, rw, a, b, aop, rs, imm, h, e};
    endfunction

    task automatic chk(string tag, logic [19:0] e);
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
`ifdef MC_RETIRE_CNT_EN
        checks++;
        assert (retired === m_ret) else begin
            errors++;
            $error("FAIL RETIRED@%s: observed %0d expected %0d", tag, retired, m_ret);
        end
`endif
    endtask

    // called at a negedge: drive, check mid-cycle, advance to next negedge
    task automatic step(string p, logic [6:0] o, logic rdy, logic z, logic tmo);
        op = o;
        mem_ready = rdy;
        zero = z;
        #1;
        chk(p, exp_vec(p, rdy, z, o, m_err, tmo));
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        mem_ready = 1'($urandom);
        #1;
        m_halt = 0;
        m_err = 0;
`ifdef MC_RETIRE_CNT_EN
        m_ret = 0;
`endif
        chk("RESET", exp_vec("FETCH", mem_ready, zero, op, 2'b00, 1'b0));
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic halt_cycles(int n);
        for (int i = 0; i < n; i++) step("HALT", 7'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    endtask

    task automatic run_instr(logic [6:0] o, logic z, int wf, int wm);
        string ph[$];
        logic  legal = 1'b1;
        case (o)
            7'b0000011: ph = '{"FETCH", "DECODE", "MEMADR", "MEMREAD", "MEMWB"};
            7'b0100011: ph = '{"FETCH", "DECODE", "MEMADR", "MEMWRITE"};
            7'b0110011: ph = '{"FETCH", "DECODE", "EXECR", "ALUWB"};
            7'b0010011: ph = '{"FETCH", "DECODE", "EXECI", "ALUWB"};
            7'b1100011: ph = '{"FETCH", "DECODE", "BEQ"};
            7'b1101111: ph = '{"FETCH", "DECODE", "JAL", "ALUWB"};
            7'b1100111: ph = '{"FETCH", "DECODE", "JALR", "JALRWB"};
            7'b0110111: ph = '{"FETCH", "DECODE", "LUI", "ALUWB"};
            7'b0010111: ph = '{"FETCH", "DECODE", "AUIPC", "ALUWB"};
            default: begin ph = '{"FETCH", "DECODE"}; legal = 1'b0; end
        endcase
        foreach (ph[i]) begin
            if (ph[i] == "FETCH" || ph[i] == "MEMREAD" || ph[i] == "MEMWRITE") begin
                int w = (ph[i] == "FETCH") ? wf : wm;
                for (int k = 0; k <= TMO; k++) begin
                    logic rdy = k >= w;
                    logic tmo = !rdy && k == TMO;
                    step(ph[i], o, rdy, z, tmo);
                    if (tmo) begin
                        m_halt = 1;
                        m_err = 2'b10;
                        return;
                    end
                    if (rdy) break;
                end
            end else step(ph[i], o, 1'($urandom), z, 1'b0);
        end
        if (!legal) begin
            m_halt = 1;
            m_err = 2'b01;
        end
`ifdef MC_RETIRE_CNT_EN
        else m_ret++;
`endif
    endtask

    initial begin
        logic [6:0] ops[10] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};
        @(negedge clk);
        do_reset();
        run_instr(7'b0110011, 1'b0, 0, 0);
        run_instr(7'b0000011, 1'b0, 0, 3);
        run_instr(7'b1100011, 1'b1, 0, 0);
        run_instr(7'b1100011, 1'b0, 0, 0);
        run_instr(7'b1100111, 1'b0, 0, 0);
        run_instr(7'b0100011, 1'b0, 1, 2);
        run_instr(7'b1101111, 1'b1, 0, 0);
        run_instr(7'b0110111, 1'b0, 2, 0);
        run_instr(7'b0010111, 1'b0, 0, 0);
        run_instr(7'b0010011, 1'b1, 0, 0);
        run_instr(7'b1111111, 1'b0, 0, 0);
        halt_cycles(20);
        do_reset();
        run_instr(7'b0110011, 1'b0, 5, 0);
        halt_cycles(3);
        do_reset();
        run_instr(7'b0110011, 1'b0, 4, 0);
        run_instr(7'b0000011, 1'b0, 0, 4);
        run_instr(7'b0100011, 1'b0, 0, 5);
        halt_cycles(3);
        do_reset();
        run_instr(7'b0000011, 1'b0, 0, 6);
        halt_cycles(2);
        do_reset();
        for (int n = 0; n < 300; n++) begin
            logic [6:0] o = ($urandom_range(0, 15) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
            int wf = ($urandom_range(0, 7) == 0) ? 5 : $urandom_range(0, 2);
            int wm = ($urandom_range(0, 5) == 0) ? $urandom_range(3, 5) : $urandom_range(0, 2);
            run_instr(o, 1'($urandom), wf, wm);
            if (m_halt) begin
                halt_cycles(2);
                do_reset();
            end
        end
        // reset arriving mid-store must drop mem_write immediately
        step("FETCH", 7'b0100011, 1'b1, 1'b0, 1'b0);
        step("DECODE", 7'b0100011, 1'b0, 1'b0, 1'b0);
        step("MEMADR", 7'b0100011, 1'b0, 1'b0, 1'b0);
        mem_ready = 1'b0;
        #1;
        chk("MEMWRITE", exp_vec("MEMWRITE", 1'b0, zero, op, 2'b00, 1'b0));
        rst = 1'b0;
        #1;
        chk("MIDRESET", exp_vec("FETCH", 1'b0, zero, op, 2'b00, 1'b0));
        @(negedge clk);
        rst = 1'b1;
        m_err = 0;
`ifdef MC_RETIRE_CNT_EN
        m_ret = 0;
`endif
        run_instr(7'b0110011, 1'b0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
